// File: rtl/cp0.sv
// cp0: coprocessor 0 of the pipelined MIPS core.
// Holds SR, Cause, EPC and PRId. Arbitrates interrupts against M-stage
// exceptions and drives the PC redirect (Req) and the eret return address.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   en, CP0Add,     mtc0 write enable, register number, write data
//   CP0In
//   VPC, BDIn,      M-stage victim PC, delay-slot flag, exception code
//   ExcCodeIn
//   HWInt           level-sensitive external interrupt lines
//   EXLClr          eret in M stage
//   CP0Out          mfc0 read data (no bypass)
//   EPC_out         return address, bypassed from a same-cycle mtc0 EPC
//   Req             take exception/interrupt this cycle (combinational)
module cp0 #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPC_out,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] vpc_aligned;
    logic [31:0] epc_exc;
    logic [31:0] cp0in_aligned;
    logic        unused_vpc_bits;

    assign unused_vpc_bits = ^VPC[1:0];

    // Request arbitration; held low during reset so no spurious redirect
    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req     = (int_req | exc_req) & ~reset;

    // Victim address: a delay-slot instruction restarts at its branch
    assign vpc_aligned   = {VPC[31:2], 2'b00};
    assign epc_exc       = BDIn ? (vpc_aligned - 32'd4) : vpc_aligned;
    assign cp0in_aligned = {CP0In[31:2], 2'b00};

    // Same-cycle bypass lets eret right after mtc0 EPC return correctly
    assign EPC_out = (en && (CP0Add == ADDR_EPC)) ? cp0in_aligned : epc_q;

    // mfc0 read mux
    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            ADDR_SR:    CP0Out = {16'd0, im_q, 8'd0, exl_q, ie_q};
            ADDR_CAUSE: CP0Out = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'b00};
            ADDR_EPC:   CP0Out = epc_q;
            ADDR_PRID:  CP0Out = PRID_VALUE;
            default:    CP0Out = 32'd0;
        endcase
    end

    // Next-state: exception entry outranks mtc0/eret
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = HWInt;

        if (Req) begin
            exl_d     = 1'b1;
            exccode_d = int_req ? 5'd0 : ExcCodeIn;
            bd_d      = BDIn;
            epc_d     = epc_exc;
        end else begin
            if (en) begin
                case (CP0Add)
                    ADDR_SR: begin
                        im_d  = CP0In[15:10];
                        exl_d = CP0In[1];
                        ie_d  = CP0In[0];
                    end
                    ADDR_EPC: epc_d = cp0in_aligned;
                    default: ;
                endcase
            end
            // eret wins over an SR write to EXL in the same cycle
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule
